// File: rtl/ula_pkg.sv
// Opcode constants, FSM encoding and opcode helpers shared by the
// ula_fx scheduler files.
package ula_pkg;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_MLT = 5'd3;
    localparam logic [4:0] OP_DIV = 5'd4;
    localparam logic [4:0] OP_MOD = 5'd5;
    localparam logic [4:0] OP_MAX = 5'd27;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic is_multi(input logic [4:0] op);
        return (op == OP_MLT) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic is_divmod(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/ula_fx_sched_if.sv
// Request/response handshake bundle between two requesters and the scheduler.
interface ula_fx_sched_if #(parameter int NUBITS = 32);

    logic [1:0]          req_vld;
    logic [1:0]          req_rdy;
    logic [9:0]          req_op;
    logic [2*NUBITS-1:0] req_in1;
    logic [2*NUBITS-1:0] req_in2;
    logic [1:0]          rsp_vld;
    logic [1:0]          rsp_rdy;
    logic [NUBITS-1:0]   rsp_out;
    logic                rsp_zero;
    logic                rsp_err;

    modport master (
        output req_vld, req_op, req_in1, req_in2, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_out, rsp_zero, rsp_err
    );

    modport slave (
        input  req_vld, req_op, req_in1, req_in2, rsp_rdy,
        output req_rdy, rsp_vld, rsp_out, rsp_zero, rsp_err
    );

endinterface

// File: rtl/ula_rr_arb.sv
// Two-way round-robin grant: the requester named by ptr wins if valid,
// otherwise the other one. Purely combinational.
module ula_rr_arb (
    input  logic [1:0] vld,
    input  logic       ptr,
    output logic       gnt_vld,
    output logic       gnt
);

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = ptr;
        if (vld[ptr]) begin
            gnt_vld = 1'b1;
            gnt     = ptr;
        end else if (vld[~ptr]) begin
            gnt_vld = 1'b1;
            gnt     = ~ptr;
        end
    end

endmodule

// File: rtl/ula_fx_sched.sv
// Time-shares one combinational ula_fx between two requesters, holding the
// ALU operands for a per-opcode number of cycles before capturing the result.
//
//   state  | meaning
//   S_IDLE | arbitrate, req_rdy to the granted requester, accept on edge
//   S_EXEC | drive latched operands to ula_fx, count down hold time
//   S_RESP | present captured result to owner until its rsp_rdy
module ula_fx_sched
    import ula_pkg::*;
#(
    parameter int NUBITS = 32,
    parameter int MC_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    ula_fx_sched_if.slave      bus,
    output logic [4:0]         ula_op,
    output logic [NUBITS-1:0]  ula_in1,
    output logic [NUBITS-1:0]  ula_in2,
    input  logic [NUBITS-1:0]  ula_out,
    input  logic               ula_zero
);

    localparam int CW = $clog2(MC_LAT + 1);

    state_t              state_q, state_nx;
    logic                ptr_q;
    logic                own_q;
    logic [CW-1:0]       cnt_q;
    logic [4:0]          op_q;
    logic [NUBITS-1:0]   in1_q, in2_q;
    logic [NUBITS-1:0]   out_q;
    logic                zero_q, err_q;

    logic                gnt_vld, gnt;
    logic [4:0]          sel_op;
    logic [NUBITS-1:0]   sel_in1, sel_in2;
    logic                accept;
    logic                div_zero;

    ula_rr_arb u_arb (
        .vld     (bus.req_vld),
        .ptr     (ptr_q),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

    assign sel_op   = gnt ? bus.req_op[9:5] : bus.req_op[4:0];
    assign sel_in1  = gnt ? bus.req_in1[NUBITS +: NUBITS] : bus.req_in1[0 +: NUBITS];
    assign sel_in2  = gnt ? bus.req_in2[NUBITS +: NUBITS] : bus.req_in2[0 +: NUBITS];
    assign accept   = (state_q == S_IDLE) && gnt_vld;
    assign div_zero = is_divmod(op_q) && (in2_q == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            S_IDLE:  if (gnt_vld)             state_nx = S_EXEC;
            S_EXEC:  if (cnt_q == '0)         state_nx = S_RESP;
            S_RESP:  if (bus.rsp_rdy[own_q])  state_nx = S_IDLE;
            default:                          state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_rdy = 2'b00;
        bus.rsp_vld = 2'b00;
        ula_op      = OP_NOP;
        ula_in1     = '0;
        ula_in2     = '0;
        // Gated by rst so nothing looks accepted while reset is held.
        if (accept && !rst) bus.req_rdy = gnt ? 2'b10 : 2'b01;
        if (state_q == S_RESP) bus.rsp_vld = own_q ? 2'b10 : 2'b01;
        if (state_q == S_EXEC) begin
            ula_op  = op_q;
            ula_in1 = in1_q;
            ula_in2 = in2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= 1'b0;
            own_q  <= 1'b0;
            cnt_q  <= '0;
            op_q   <= OP_NOP;
            in1_q  <= '0;
            in2_q  <= '0;
            out_q  <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            op_q  <= sel_op;
            in1_q <= sel_in1;
            in2_q <= sel_in2;
            own_q <= gnt;
            ptr_q <= ~gnt;
            cnt_q <= is_multi(sel_op) ? CW'(MC_LAT - 1) : '0;
        end else if (state_q == S_EXEC) begin
            if (cnt_q == '0) begin
                // Divide by zero result is forced, whatever ula_fx produced.
                out_q  <= div_zero ? '0 : ula_out;
                zero_q <= div_zero ? 1'b1 : ula_zero;
                err_q  <= div_zero || (op_q > OP_MAX);
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign bus.rsp_out  = out_q;
    assign bus.rsp_zero = zero_q;
    assign bus.rsp_err  = err_q;

endmodule

// File: tb/tb_ula_fx_sched.sv
// Directed bench for ula_fx_sched with a behavioural ula_fx stand-in
// (ADD, MLT, DIV, MOD; unknown opcodes give in1^in2).
module tb_ula_fx_sched;

    localparam int NB = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      ula_op;
    logic [NB-1:0]   ula_in1, ula_in2, ula_out;
    logic            ula_zero;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ula_fx_sched_if #(.NUBITS(NB)) bus ();

    ula_fx_sched #(.NUBITS(NB), .MC_LAT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .ula_op   (ula_op),
        .ula_in1  (ula_in1),
        .ula_in2  (ula_in2),
        .ula_out  (ula_out),
        .ula_zero (ula_zero)
    );

    // Divide by zero returns in1 so the scheduler's override is observable.
    always_comb begin
        ula_out = '0;
        case (ula_op)
            5'd0:    ula_out = '0;
            5'd2:    ula_out = ula_in1 + ula_in2;
            5'd3:    ula_out = ula_in1 * ula_in2;
            5'd4:    ula_out = (ula_in2 == '0) ? ula_in1 : ula_in1 / ula_in2;
            5'd5:    ula_out = (ula_in2 == '0) ? ula_in1 : ula_in1 % ula_in2;
            default: ula_out = ula_in1 ^ ula_in2;
        endcase
        ula_zero = (ula_out == '0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [4:0] op,
                           input logic [NB-1:0] a, input logic [NB-1:0] b);
        bus.req_vld[r] = 1'b1;
        if (r == 0) begin
            bus.req_op[4:0]     = op;
            bus.req_in1[NB-1:0] = a;
            bus.req_in2[NB-1:0] = b;
        end else begin
            bus.req_op[9:5]        = op;
            bus.req_in1[2*NB-1:NB] = a;
            bus.req_in2[2*NB-1:NB] = b;
        end
    endtask

    // Single-requester transaction, from request through response handshake.
    task automatic run_op(input string tag, input int r, input logic [4:0] op,
                          input logic [NB-1:0] a, input logic [NB-1:0] b, input int lat,
                          input logic [NB-1:0] e_out, input logic e_zero, input logic e_err);
        logic [1:0] oh;
        oh = (r == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        set_req(r, op, a, b);
        #1 chk({tag, "_rdy"}, bus.req_rdy, oh);
        @(negedge clk);
        bus.req_vld = 2'b00;
        for (int i = 0; i < lat; i++) begin
            chk({tag, "_exec_op"}, ula_op, op);
            chk({tag, "_exec_in1"}, ula_in1, a);
            chk({tag, "_exec_novld"}, bus.rsp_vld, 2'b00);
            @(negedge clk);
        end
        chk({tag, "_vld"}, bus.rsp_vld, oh);
        chk({tag, "_out"}, bus.rsp_out, e_out);
        chk({tag, "_zero"}, bus.rsp_zero, e_zero);
        chk({tag, "_err"}, bus.rsp_err, e_err);
        chk({tag, "_nop"}, ula_op, 5'd0);
        bus.rsp_rdy = oh;
        @(negedge clk);
        bus.rsp_rdy = 2'b00;
        chk({tag, "_done"}, bus.rsp_vld, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g;
        rst         = 1'b1;
        bus.req_vld = 2'b11;
        bus.req_op  = '0;
        bus.req_in1 = '0;
        bus.req_in2 = '0;
        bus.rsp_rdy = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_req_rdy", bus.req_rdy, 2'b00);
        chk("rst_rsp_vld", bus.rsp_vld, 2'b00);
        chk("rst_rsp_out", bus.rsp_out, 32'd0);
        chk("rst_rsp_zero", bus.rsp_zero, 1'b0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_ula_op", ula_op, 5'd0);
        chk("rst_ula_in", {ula_in1, ula_in2}, 64'd0);
        bus.req_vld = 2'b00;
        rst = 1'b0;

        run_op("t1_add", 0, 5'd2, 32'd5, 32'd7, 1, 32'd12, 1'b0, 1'b0);
        run_op("t3_div", 1, 5'd4, 32'd100, 32'd7, 4, 32'd14, 1'b0, 1'b0);

        // Both valid continuously: grants 0,1,0, owner's rsp_rdy held high.
        @(negedge clk);
        set_req(0, 5'd2, 32'd1, 32'd1);
        set_req(1, 5'd2, 32'd2, 32'd2);
        bus.rsp_rdy = 2'b11;
        for (int k = 0; k < 3; k++) begin
            g = (k == 1);
            #1 chk("t2_rdy", bus.req_rdy, g ? 2'b10 : 2'b01);
            @(negedge clk);
            chk("t2_exec_in1", ula_in1, g ? 32'd2 : 32'd1);
            @(negedge clk);
            chk("t2_vld", bus.rsp_vld, g ? 2'b10 : 2'b01);
            chk("t2_out", bus.rsp_out, g ? 32'd4 : 32'd2);
            @(negedge clk);
        end
        bus.req_vld = 2'b00;
        bus.rsp_rdy = 2'b00;

        run_op("t4_mod0", 0, 5'd5, 32'd9, 32'd0, 4, 32'd0, 1'b1, 1'b1);
        run_op("t4_bad", 0, 5'd31, 32'd6, 32'd3, 1, 32'd5, 1'b0, 1'b1);

        // Response back-pressure with the other requester waiting.
        @(negedge clk);
        set_req(0, 5'd2, 32'd3, 32'd4);
        #1 chk("t5_rdy0", bus.req_rdy, 2'b01);
        @(negedge clk);
        bus.req_vld = 2'b00;
        set_req(1, 5'd2, 32'd10, 32'd20);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bus.rsp_rdy = 2'b10;
            #1;
            chk("t5_hold_vld", bus.rsp_vld, 2'b01);
            chk("t5_hold_out", bus.rsp_out, 32'd7);
            chk("t5_hold_rdy", bus.req_rdy, 2'b00);
            @(negedge clk);
        end
        bus.rsp_rdy = 2'b01;
        @(negedge clk);
        bus.rsp_rdy = 2'b00;
        chk("t5_idle_vld", bus.rsp_vld, 2'b00);
        #1 chk("t5_rdy1", bus.req_rdy, 2'b10);
        @(negedge clk);
        bus.req_vld = 2'b00;
        chk("t5_exec1", ula_in1, 32'd10);
        @(negedge clk);
        chk("t5_vld1", bus.rsp_vld, 2'b10);
        chk("t5_out1", bus.rsp_out, 32'd30);
        bus.rsp_rdy = 2'b10;
        @(negedge clk);
        bus.rsp_rdy = 2'b00;

        // Reset in the second EXEC cycle of a DIV from requester 0.
        @(negedge clk);
        set_req(0, 5'd4, 32'd100, 32'd7);
        #1 chk("t6_rdy", bus.req_rdy, 2'b01);
        @(negedge clk);
        bus.req_vld = 2'b00;
        chk("t6_exec", ula_op, 5'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_vld", bus.rsp_vld, 2'b00);
        chk("t6_rst_op", ula_op, 5'd0);
        chk("t6_rst_out", bus.rsp_out, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t6_no_stale_vld", bus.rsp_vld, 2'b00);
            chk("t6_no_stale_op", ula_op, 5'd0);
        end
        bus.req_vld = 2'b11;
        #1 chk("t6_ptr0", bus.req_rdy, 2'b01);
        @(negedge clk);
        bus.req_vld = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
